aclk_timegen_param: RTL and testbench

Parametrised time-base generator for the alarm-clock datapath, replacing the fixed 256-clk/second, 60-second/minute generator. It divides the input clock into one-cycle second and minute pulses, with configurable divider ratios, a run/pause enable and a 3-way fast-watch mode. It also exposes live second and minute counts for display and debug. Its pulses drive the alarm-clock counter and FSM blocks.

---
 rtl/aclk_timegen_param.sv | 120 ++++++++++++
 tb/tb_aclk_timegen_param.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aclk_timegen_param.sv
// aclk_timegen_param: parametrised time base for the alarm clock.
// Divides clk into one-cycle second and minute pulses and exposes the live
// second/minute counts. Optional build macro ACLK_TIMEGEN_HOUR_EN adds a
// one-cycle hour pulse on the minute-counter wrap.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   reset_count  synchronous clear of all counters and registered pulses
//   enable       1 = run, 0 = freeze counters (pulses drop on next edge)
//   fast_mode    00/11 normal, 01 minute = second, 10 minute every enabled cycle
//   one_second   one-cycle second pulse
//   one_minute   minute pulse selected by fast_mode
//   one_hour     one-cycle hour pulse (ACLK_TIMEGEN_HOUR_EN only)
//   sec_count    current second, 0..SEC_PER_MIN-1
//   min_count    current minute, 0..MIN_PER_HOUR-1
module aclk_timegen_param #(
  parameter int unsigned CLK_PER_SEC  = 256,
  parameter int unsigned SEC_PER_MIN  = 60,
  parameter int unsigned MIN_PER_HOUR = 60,
  parameter int unsigned PS_W         = $clog2(CLK_PER_SEC),
  parameter int unsigned SEC_W        = $clog2(SEC_PER_MIN),
  parameter int unsigned MIN_W        = $clog2(MIN_PER_HOUR)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             reset_count,
  input  logic             enable,
  input  logic [1:0]       fast_mode,
  output logic             one_second,
  output logic             one_minute,
`ifdef ACLK_TIMEGEN_HOUR_EN
  output logic             one_hour,
`endif
  output logic [SEC_W-1:0] sec_count,
  output logic [MIN_W-1:0] min_count
);

  localparam logic [PS_W-1:0]  PsLast  = PS_W'(CLK_PER_SEC - 1);
  localparam logic [SEC_W-1:0] SecLast = SEC_W'(SEC_PER_MIN - 1);
  localparam logic [MIN_W-1:0] MinLast = MIN_W'(MIN_PER_HOUR - 1);

  logic [PS_W-1:0]  prescaler_q;
  logic [SEC_W-1:0] sec_q;
  logic [MIN_W-1:0] min_q;
  logic             sec_pulse_q;
  logic             min_pulse_q;

  logic ps_wrap, sec_wrap, min_wrap;

  assign ps_wrap  = (prescaler_q == PsLast);
  assign sec_wrap = ps_wrap & (sec_q == SecLast);
  assign min_wrap = sec_wrap & (min_q == MinLast);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler_q <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      sec_pulse_q <= 1'b0;
      min_pulse_q <= 1'b0;
    end else if (reset_count) begin
      prescaler_q <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      sec_pulse_q <= 1'b0;
      min_pulse_q <= 1'b0;
    end else if (!enable) begin
      // Counters hold; pulses only last one cycle so they drop here.
      sec_pulse_q <= 1'b0;
      min_pulse_q <= 1'b0;
    end else begin
      sec_pulse_q <= ps_wrap;
      min_pulse_q <= sec_wrap;
      prescaler_q <= ps_wrap ? '0 : prescaler_q + 1'b1;
      if (ps_wrap) begin
        sec_q <= (sec_q == SecLast) ? '0 : sec_q + 1'b1;
      end
      if (sec_wrap) begin
        min_q <= (min_q == MinLast) ? '0 : min_q + 1'b1;
      end
    end
  end

`ifdef ACLK_TIMEGEN_HOUR_EN
  logic hour_pulse_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hour_pulse_q <= 1'b0;
    end else if (reset_count || !enable) begin
      hour_pulse_q <= 1'b0;
    end else begin
      hour_pulse_q <= min_wrap;
    end
  end

  assign one_hour = hour_pulse_q;
`else
  logic unused_min_wrap;
  assign unused_min_wrap = min_wrap;
`endif

  // Mode select is combinational so a mode change shows in the same cycle;
  // reset_count forces the minute output low in every mode.
  always_comb begin
    one_minute = 1'b0;
    case (fast_mode)
      2'b01:   one_minute = sec_pulse_q;
      2'b10:   one_minute = enable;
      default: one_minute = min_pulse_q;
    endcase
    one_minute = one_minute & ~reset_count;
  end

  assign one_second = sec_pulse_q;
  assign sec_count  = sec_q;
  assign min_count  = min_q;

endmodule

// File: tb/tb_aclk_timegen_param.sv
module tb_aclk_timegen_param;

  localparam int CPS = 4;
  localparam int SPM = 3;
  localparam int MPH = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       reset_count = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] fast_mode = 2'b00;
  logic       one_second;
  logic       one_minute;
  logic [1:0] sec_count;
  logic [0:0] min_count;
`ifdef ACLK_TIMEGEN_HOUR_EN
  logic       one_hour;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: number of counting edges since the last clear, and
  // whether the most recent edge was a counting edge.
  int ticks = 0;
  bit counted = 1'b0;

  aclk_timegen_param #(
    .CLK_PER_SEC (CPS),
    .SEC_PER_MIN (SPM),
    .MIN_PER_HOUR(MPH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .reset_count(reset_count),
    .enable     (enable),
    .fast_mode  (fast_mode),
    .one_second (one_second),
    .one_minute (one_minute),
`ifdef ACLK_TIMEGEN_HOUR_EN
    .one_hour   (one_hour),
`endif
    .sec_count  (sec_count),
    .min_count  (min_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1);
  end

  function automatic logic e_sec_p();
    return counted && (ticks % CPS == 0);
  endfunction

  function automatic logic e_min_p();
    return counted && (ticks % (CPS * SPM) == 0);
  endfunction

  function automatic logic e_hour_p();
    return counted && (ticks % (CPS * SPM * MPH) == 0);
  endfunction

  function automatic logic [1:0] e_sec();
    return 2'((ticks / CPS) % SPM);
  endfunction

  function automatic logic [0:0] e_min();
    return 1'((ticks / (CPS * SPM)) % MPH);
  endfunction

  function automatic logic e_om();
    logic v;
    case (fast_mode)
      2'b01:   v = e_sec_p();
      2'b10:   v = enable;
      default: v = e_min_p();
    endcase
    return v & ~reset_count;
  endfunction

  // Advance n clock edges, updating the model, then settle 1 time unit.
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      if (reset_count) begin
        ticks = 0;
        counted = 1'b0;
      end else if (!enable) begin
        counted = 1'b0;
      end else begin
        ticks++;
        counted = 1'b1;
      end
      #1;
    end
  endtask

  task automatic test_reset();
    enable = 1'b1;
    fast_mode = 2'b00;
    #12;
    checks++;
    if (one_second !== 1'b0) begin
      errors++; $display("FAIL reset_one_second got %b required 0", one_second);
    end
    checks++;
    if (one_minute !== 1'b0) begin
      errors++; $display("FAIL reset_one_minute got %b required 0", one_minute);
    end
    checks++;
    if (sec_count !== 2'd0 || min_count !== 1'd0) begin
      errors++; $display("FAIL reset_counts got sec=%0d min=%0d required 0/0", sec_count, min_count);
    end
`ifdef ACLK_TIMEGEN_HOUR_EN
    checks++;
    if (one_hour !== 1'b0) begin
      errors++; $display("FAIL reset_one_hour got %b required 0", one_hour);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    ticks = 0;
    counted = 1'b0;
  endtask

  task automatic test_normal();
    for (int i = 1; i <= CPS * SPM * MPH; i++) begin
      adv(1);
      checks++;
      if (one_second !== e_sec_p()) begin
        errors++; $display("FAIL normal_one_second edge %0d got %b required %b", i, one_second, e_sec_p());
      end
      checks++;
      if (one_minute !== e_om()) begin
        errors++; $display("FAIL normal_one_minute edge %0d got %b required %b", i, one_minute, e_om());
      end
      checks++;
      if (sec_count !== e_sec() || min_count !== e_min()) begin
        errors++;
        $display("FAIL normal_counts edge %0d got sec=%0d min=%0d required sec=%0d min=%0d",
                 i, sec_count, min_count, e_sec(), e_min());
      end
`ifdef ACLK_TIMEGEN_HOUR_EN
      checks++;
      if (one_hour !== e_hour_p()) begin
        errors++; $display("FAIL normal_one_hour edge %0d got %b required %b", i, one_hour, e_hour_p());
      end
`endif
    end
    // Directed: after 24 edges minute count is back to 0 and a minute just fired.
    checks++;
    if (min_count !== 1'd0 || one_minute !== 1'b1) begin
      errors++; $display("FAIL normal_hour_wrap got min=%0d om=%b required min=0 om=1", min_count, one_minute);
    end
  endtask

  task automatic test_enable();
    logic [1:0] s_hold;
    logic [0:0] m_hold;
    for (int i = 0; i < 8 && (ticks % CPS) != 2; i++) adv(1);
    s_hold = e_sec();
    m_hold = e_min();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      adv(1);
      checks++;
      if (sec_count !== s_hold || min_count !== m_hold) begin
        errors++;
        $display("FAIL enable_frozen cycle %0d got sec=%0d min=%0d required sec=%0d min=%0d",
                 i, sec_count, min_count, s_hold, m_hold);
      end
      checks++;
      if (one_second !== 1'b0 || one_minute !== 1'b0) begin
        errors++; $display("FAIL enable_no_pulse cycle %0d got 1s=%b 1m=%b required 0/0", i, one_second, one_minute);
      end
    end
    enable = 1'b1;
    adv(1);
    checks++;
    if (one_second !== 1'b0) begin
      errors++; $display("FAIL enable_resume_early got %b required 0", one_second);
    end
    adv(1);
    checks++;
    if (one_second !== 1'b1 || one_second !== e_sec_p()) begin
      errors++; $display("FAIL enable_resume_pulse got %b required 1", one_second);
    end
  endtask

  task automatic test_reset_count();
    for (int i = 0; i < 16 && !(e_sec() == 2'd2 && (ticks % CPS) == 1); i++) adv(1);
    reset_count = 1'b1;
    adv(1);
    reset_count = 1'b0;
    checks++;
    if (sec_count !== 2'd0 || min_count !== 1'd0 || one_second !== 1'b0) begin
      errors++;
      $display("FAIL rc_clear got sec=%0d min=%0d 1s=%b required 0/0/0", sec_count, min_count, one_second);
    end
    for (int i = 1; i <= 3; i++) begin
      adv(1);
      checks++;
      if (one_second !== 1'b0) begin
        errors++; $display("FAIL rc_early_pulse edge %0d got %b required 0", i, one_second);
      end
    end
    adv(1);
    checks++;
    if (one_second !== 1'b1 || sec_count !== 2'd1 || one_minute !== 1'b0) begin
      errors++;
      $display("FAIL rc_first_second got 1s=%b sec=%0d 1m=%b required 1/1/0", one_second, sec_count, one_minute);
    end
  endtask

  task automatic test_fast_mode();
    fast_mode = 2'b01;
    for (int i = 0; i < 12; i++) begin
      adv(1);
      checks++;
      if (one_minute !== e_sec_p() || one_minute !== one_second) begin
        errors++; $display("FAIL fast01 cycle %0d got %b required %b", i, one_minute, e_sec_p());
      end
    end
    for (int i = 0; i < 8 && !e_sec_p(); i++) adv(1);
    reset_count = 1'b1;
    #1;
    checks++;
    if (one_minute !== 1'b0) begin
      errors++; $display("FAIL fast01_rc_gate got %b required 0", one_minute);
    end
    reset_count = 1'b0;
    fast_mode = 2'b10;
    #1;
    checks++;
    if (one_minute !== 1'b1) begin
      errors++; $display("FAIL fast10_immediate got %b required 1", one_minute);
    end
    for (int i = 0; i < 6; i++) begin
      enable = (i != 3);
      adv(1);
      checks++;
      if (one_minute !== e_om()) begin
        errors++; $display("FAIL fast10 cycle %0d got %b required %b", i, one_minute, e_om());
      end
    end
    enable = 1'b1;
    fast_mode = 2'b11;
    for (int i = 0; i < 16; i++) begin
      adv(1);
      checks++;
      if (one_minute !== e_min_p()) begin
        errors++; $display("FAIL fast11 cycle %0d got %b required %b", i, one_minute, e_min_p());
      end
    end
    fast_mode = 2'b00;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      reset_count = ($urandom_range(0, 39) == 0);
      fast_mode = 2'($urandom_range(0, 3));
      adv(1);
      checks++;
      if (one_second !== e_sec_p() || one_minute !== e_om()) begin
        errors++;
        $display("FAIL random_pulses cycle %0d got 1s=%b 1m=%b required 1s=%b 1m=%b",
                 i, one_second, one_minute, e_sec_p(), e_om());
      end
      checks++;
      if (sec_count !== e_sec() || min_count !== e_min()) begin
        errors++;
        $display("FAIL random_counts cycle %0d got sec=%0d min=%0d required sec=%0d min=%0d",
                 i, sec_count, min_count, e_sec(), e_min());
      end
`ifdef ACLK_TIMEGEN_HOUR_EN
      checks++;
      if (one_hour !== e_hour_p()) begin
        errors++; $display("FAIL random_one_hour cycle %0d got %b required %b", i, one_hour, e_hour_p());
      end
`endif
    end
    enable = 1'b1;
    reset_count = 1'b0;
    fast_mode = 2'b00;
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      adv(1);
      found = (one_second === 1'b1) && (sec_count !== 2'd0);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL async_setup got no pulse with sec!=0 required one within 40 edges");
    end
    #2;
    reset_n = 1'b0;
    ticks = 0;
    counted = 1'b0;
    #1;
    checks++;
    if (one_second !== 1'b0 || sec_count !== 2'd0 || min_count !== 1'd0) begin
      errors++;
      $display("FAIL async_reset got 1s=%b sec=%0d min=%0d required 0/0/0", one_second, sec_count, min_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 1; i <= CPS; i++) begin
      adv(1);
      checks++;
      if (one_second !== e_sec_p() || sec_count !== e_sec()) begin
        errors++;
        $display("FAIL async_restart edge %0d got 1s=%b sec=%0d required 1s=%b sec=%0d",
                 i, one_second, sec_count, e_sec_p(), e_sec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_enable();
    test_reset_count();
    test_fast_mode();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
